ram_arbiter: RTL and testbench

- Two-requester round-robin arbiter and sequencer for the single-port synchronous RAM (1-cycle registered read, data output held on write cycles).
- Shares the RAM between two valid/ready requesters and returns read data to the issuing requester one cycle after grant.
- Includes a clear sequencer that zero-fills every RAM word on request.
- Sits between the requesters and the RAM instance; drives the RAM address, write data and write-enable directly.

---
 rtl/ram_arbiter.sv | 116 +++++++++++
 tb/tb_ram_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter for two requesters sharing one single-port synchronous RAM,
// plus a sequencer that zero-fills the whole RAM on request.
module ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_valid_i,
    output logic              r0_ready_o,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_rvalid_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    input  logic              r1_valid_i,
    output logic              r1_ready_o,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_rvalid_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    input  logic              clear_i,
    output logic              busy_o,
    output logic              clear_done_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);

    typedef enum logic {ARB, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic              last_q;      // 1: requester 1 was granted last
    logic              rd_pend_q;
    logic              rd_owner_q;
    logic              done_q;
    logic              gnt0, gnt1;

    // Handshake: a request transfers in the cycle where valid and ready are both
    // high; ready is combinational and only ever high for the granted requester.
    always_comb begin
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        state_d     = state_q;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        if (!rst_i) begin
            case (state_q)
                ARB: begin
                    if (r0_valid_i && (!r1_valid_i || last_q)) begin
                        gnt0 = 1'b1;
                    end else if (r1_valid_i) begin
                        gnt1 = 1'b1;
                    end
                    if (gnt0) begin
                        ram_we_o    = r0_we_i;
                        ram_addr_o  = r0_addr_i;
                        ram_wdata_o = r0_wdata_i;
                    end else if (gnt1) begin
                        ram_we_o    = r1_we_i;
                        ram_addr_o  = r1_addr_i;
                        ram_wdata_o = r1_wdata_i;
                    end
                    if (clear_i) begin
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    ram_we_o   = 1'b1;
                    ram_addr_o = cnt_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ARB;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= (state_q == CLEAR) ? cnt_q + 1'b1 : '0;
            done_q    <= (state_q == CLEAR) && (cnt_q == CNT_LAST);
            rd_pend_q <= (gnt0 && !r0_we_i) || (gnt1 && !r1_we_i);
            if (gnt0 || gnt1) begin
                last_q     <= gnt1;
                rd_owner_q <= gnt1;
            end
        end
    end

    assign r0_ready_o   = gnt0;
    assign r1_ready_o   = gnt1;
    assign busy_o       = (state_q == CLEAR);
    assign clear_done_o = done_q;
    // The RAM's registered output already holds the read word; just steer it.
    assign r0_rvalid_o  = rd_pend_q && !rd_owner_q;
    assign r1_rvalid_o  = rd_pend_q && rd_owner_q;
    assign r0_rdata_o   = r0_rvalid_o ? ram_rdata_i : '0;
    assign r1_rdata_o   = r1_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus a randomized phase, checked against a
// memory/queue reference model; includes a behavioural single-port RAM.
module tb_ram_arbiter;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0_valid = 1'b0, r0_we = 1'b0, r1_valid = 1'b0, r1_we = 1'b0, clr = 1'b0;
    logic [AW-1:0] r0_addr = '0, r1_addr = '0;
    logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
    logic          r0_ready_o, r1_ready_o, r0_rvalid_o, r1_rvalid_o;
    logic [DW-1:0] r0_rdata_o, r1_rdata_o;
    logic          busy_o, clear_done_o, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready_o), .r0_we_i(r0_we),
        .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata),
        .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready_o), .r1_we_i(r1_we),
        .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata),
        .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o),
        .clear_i(clr), .busy_o(busy_o), .clear_done_o(clear_done_o),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_we_o(ram_we),
        .ram_rdata_i(ram_rdata)
    );

    // Single-port RAM: registered read, output held on write cycles.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        else        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state
    logic [DW-1:0] exp_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            own_q[$];
    int            last_gnt;
    int            clr_left;
    logic          done_flag;
    int            n_checks = 0;
    int            n_fail = 0;
    int            busy_cnt, done_cnt;
    logic          o0, o1;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        own_q.delete();
        last_gnt  = 1;
        clr_left  = 0;
        done_flag = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; r0_we = 1'b1; r1_we = 1'b1; clr = 1'b0;
        #1;
        check("rst_r0_ready", DW'(r0_ready_o), '0);
        check("rst_r1_ready", DW'(r1_ready_o), '0);
        check("rst_ram_we", DW'(ram_we), '0);
        @(posedge clk);
        model_reset();
    endtask

    task automatic cycle(input logic v0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic c, output logic g0, output logic g1);
        logic          eg0, eg1, ew, done_now;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        int            qo;
        @(negedge clk);
        rst = 1'b0;
        r0_valid = v0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
        clr = c;
        #1;
        g0 = r0_ready_o;
        g1 = r1_ready_o;
        done_now  = done_flag;
        done_flag = 1'b0;
        if (busy_o) busy_cnt++;
        if (clear_done_o) done_cnt++;
        check("busy", DW'(busy_o), DW'(clr_left > 0));
        check("clear_done", DW'(clear_done_o), DW'(done_now));
        if (exp_q.size() > 0) begin
            ed = exp_q.pop_front();
            qo = own_q.pop_front();
            check("r0_rvalid", DW'(r0_rvalid_o), DW'(qo == 0));
            check("r1_rvalid", DW'(r1_rvalid_o), DW'(qo == 1));
            check("rdata", (qo == 0) ? r0_rdata_o : r1_rdata_o, ed);
        end else begin
            check("r0_rvalid_idle", DW'(r0_rvalid_o), '0);
            check("r1_rvalid_idle", DW'(r1_rvalid_o), '0);
        end
        if (clr_left > 0) begin
            ea = AW'(DEPTH - clr_left);
            check("clr_r0_ready", DW'(r0_ready_o), '0);
            check("clr_r1_ready", DW'(r1_ready_o), '0);
            check("clr_ram_we", DW'(ram_we), 1);
            check("clr_ram_addr", DW'(ram_addr), DW'(ea));
            check("clr_ram_wdata", ram_wdata, '0);
            exp_mem[ea] = '0;
            clr_left--;
            if (clr_left == 0) done_flag = 1'b1;
        end else begin
            if (v0 && v1) begin
                eg0 = (last_gnt == 1);
                eg1 = !eg0;
            end else begin
                eg0 = v0;
                eg1 = v1;
            end
            check("r0_ready", DW'(r0_ready_o), DW'(eg0));
            check("r1_ready", DW'(r1_ready_o), DW'(eg1));
            if (eg0 || eg1) begin
                ew = eg0 ? w0 : w1;
                ea = eg0 ? a0 : a1;
                ed = eg0 ? d0 : d1;
                check("ram_we", DW'(ram_we), DW'(ew));
                check("ram_addr", DW'(ram_addr), DW'(ea));
                if (ew) begin
                    check("ram_wdata", ram_wdata, ed);
                    exp_mem[ea] = ed;
                end else begin
                    exp_q.push_back(exp_mem[ea]);
                    own_q.push_back(eg1 ? 1 : 0);
                end
                last_gnt = eg1 ? 1 : 0;
            end else begin
                check("idle_ram_we", DW'(ram_we), '0);
                check("idle_ram_addr", DW'(ram_addr), '0);
                check("idle_ram_wdata", ram_wdata, '0);
            end
            if (c) clr_left = DEPTH;
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, '0, 0, 0, '0, '0, 0, o0, o1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          hv0, hv1, hw0, hw1;
        logic [AW-1:0] ha0, ha1;
        logic [DW-1:0] hd0, hd1;
        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = '0;
            exp_mem[i] = '0;
        end
        model_reset();
        do_reset();
        idle(1);

        // Write then read back on requester 0
        cycle(1, 1, 8'h10, 32'hDEADBEEF, 0, 0, '0, '0, 0, o0, o1);
        cycle(1, 0, 8'h10, '0, 0, 0, '0, '0, 0, o0, o1);
        check("t1_read_grant", DW'(o0), 1);
        idle(1);

        // Alternating grants under continuous contention
        cycle(1, 1, 8'h01, 32'h11, 0, 0, '0, '0, 0, o0, o1);
        cycle(0, 0, '0, '0, 1, 1, 8'h02, 32'h22, 0, o0, o1);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 8'h01, '0, 1, 0, 8'h02, '0, 0, o0, o1);
            check("t2_alt_r0", DW'(o0), DW'(i % 2 == 0));
            check("t2_alt_r1", DW'(o1), DW'(i % 2 == 1));
        end
        idle(1);

        // Lone requester 1, then contention goes to requester 0
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, '0, '0, 1, 0, 8'h02, '0, 0, o0, o1);
            check("t3_lone_r1", DW'(o1), 1);
        end
        cycle(1, 0, 8'h01, '0, 1, 0, 8'h02, '0, 0, o0, o1);
        check("t3_contend_r0", DW'(o0), 1);
        idle(2);

        // Full clear with requests held off
        cycle(1, 1, 8'h00, 32'hA5A5A5A5, 0, 0, '0, '0, 0, o0, o1);
        cycle(1, 1, 8'hFF, 32'hA5A5A5A5, 0, 0, '0, '0, 0, o0, o1);
        busy_cnt = 0;
        done_cnt = 0;
        cycle(0, 0, '0, '0, 0, 0, '0, '0, 1, o0, o1);
        for (int i = 0; i < 270; i++) cycle(1, 0, 8'h33, '0, 1, 0, 8'h33, '0, 0, o0, o1);
        check("t4_busy_cycles", DW'(busy_cnt), 256);
        check("t4_done_pulses", DW'(done_cnt), 1);
        cycle(1, 0, 8'h00, '0, 0, 0, '0, '0, 0, o0, o1);
        cycle(0, 0, '0, '0, 1, 0, 8'hFF, '0, 0, o0, o1);
        idle(1);

        // Clear pulse coincident with a granted read
        cycle(1, 1, 8'h05, 32'h55, 0, 0, '0, '0, 0, o0, o1);
        busy_cnt = 0;
        done_cnt = 0;
        cycle(1, 0, 8'h05, '0, 0, 0, '0, '0, 1, o0, o1);
        check("t5_entry_grant", DW'(o0), 1);
        idle(260);
        check("t5_busy_cycles", DW'(busy_cnt), 256);
        check("t5_done_pulses", DW'(done_cnt), 1);

        // Reset in the middle of a clear
        cycle(1, 1, 8'h64, 32'h12345678, 0, 0, '0, '0, 0, o0, o1);
        cycle(0, 0, '0, '0, 0, 0, '0, '0, 1, o0, o1);
        idle(100);
        do_reset();
        done_cnt = 0;
        idle(2);
        for (int a = 0; a <= 8'h64; a++) cycle(1, 0, AW'(a), '0, 0, 0, '0, '0, 0, o0, o1);
        idle(1);
        check("t6_no_done_pulse", DW'(done_cnt), '0);

        // Randomized traffic with valid held until ready
        hv0 = 1'b0; hv1 = 1'b0;
        hw0 = 1'b0; hw1 = 1'b0; ha0 = '0; ha1 = '0; hd0 = '0; hd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hv0) begin
                hv0 = ($urandom_range(0, 99) < 60);
                hw0 = 1'($urandom_range(0, 1));
                ha0 = AW'($urandom_range(0, 15));
                hd0 = $urandom;
            end
            if (!hv1) begin
                hv1 = ($urandom_range(0, 99) < 60);
                hw1 = 1'($urandom_range(0, 1));
                ha1 = AW'($urandom_range(0, 15));
                hd1 = $urandom;
            end
            cycle(hv0, hw0, ha0, hd0, hv1, hw1, ha1, hd1, 0, o0, o1);
            if (o0) hv0 = 1'b0;
            if (o1) hv1 = 1'b0;
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
